// File: rtl/debug_controller_pkg.sv
// Shared command opcodes, default widths and FSM state type for the MIPS debug unit.
package debug_controller_pkg;

    localparam int DEF_UART_BITS        = 8;
    localparam int DEF_INSTRUCTION_BITS = 32;
    localparam int DEF_INST_ADDRS_BITS  = 8;
    localparam int DEF_CLK_COUNT_BITS   = 8;

    localparam logic [7:0] CMD_LOAD  = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] CMD_STEP  = 8'h03;
    localparam logic [7:0] CMD_RESET = 8'h04;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_COUNT = 3'd1,
        LOAD_BYTES = 3'd2,
        LOAD_WRITE = 3'd3,
        RUN        = 3'd4,
        STEP       = 3'd5,
        SEND_START = 3'd6,
        SEND_WAIT  = 3'd7
    } dbg_state_t;

endpackage

// File: rtl/debug_controller_inst.sv
// Big-endian byte-to-word assembler: first byte lands in the most significant lane.
module inst_assembler
    import debug_controller_pkg::*;
#(
    parameter int UART_BITS = DEF_UART_BITS,
    parameter int WORD_BITS = DEF_INSTRUCTION_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 byte_valid,
    input  logic [UART_BITS-1:0] byte_data,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_ready
);
    localparam int BYTES = WORD_BITS / UART_BITS;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    // Only the bytes already received are held; the last byte is forwarded straight through
    // so the word is usable in the same cycle as its final byte.
    logic [WORD_BITS-UART_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]               count_reg;

    assign word       = {shift_reg, byte_data};
    assign word_ready = byte_valid && (count_reg == CNT_W'(BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_reg <= '0;
            count_reg <= '0;
        end else if (byte_valid) begin
            shift_reg <= word[WORD_BITS-UART_BITS-1:0];
            count_reg <= word_ready ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/debug_controller.sv
// Debug-unit sequencer: decodes UART commands, loads instruction memory, runs/steps the
// pipeline with a saturating cycle counter and hands off to the data-dump FSM.
module debug_controller
    import debug_controller_pkg::*;
#(
    parameter int UART_BITS        = DEF_UART_BITS,
    parameter int INSTRUCTION_BITS = DEF_INSTRUCTION_BITS,
    parameter int INST_ADDRS_BITS  = DEF_INST_ADDRS_BITS,
    parameter int CLK_COUNT_BITS   = DEF_CLK_COUNT_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_rx_done,
    input  logic [UART_BITS-1:0]        i_rx_data,
    input  logic                        i_halt,
    input  logic                        i_send_done,
    output logic                        o_send_start,
    output logic                        o_proc_enable,
    output logic                        o_proc_reset,
    output logic                        o_inst_write,
    output logic [INST_ADDRS_BITS-1:0]  o_inst_address,
    output logic [INSTRUCTION_BITS-1:0] o_inst_data,
    output logic [CLK_COUNT_BITS-1:0]   o_clk_count,
    output logic                        o_busy
);
    dbg_state_t                  state_reg;
    logic [INST_ADDRS_BITS-1:0]  word_count_reg;
    logic [INST_ADDRS_BITS-1:0]  index_reg;
    logic                        last_reg;
    logic                        halted_reg;
    logic                        send_start_reg;
    logic                        proc_enable_reg;
    logic                        proc_reset_reg;
    logic                        inst_write_reg;
    logic [INST_ADDRS_BITS-1:0]  inst_address_reg;
    logic [INSTRUCTION_BITS-1:0] inst_data_reg;
    logic [CLK_COUNT_BITS-1:0]   clk_count_reg;
    logic                        busy_reg;

    logic                        asm_valid;
    logic [INSTRUCTION_BITS-1:0] asm_word;
    logic                        asm_ready;
    logic                        is_last_word;

    assign asm_valid    = i_rx_done && (state_reg == LOAD_BYTES);
    // Word count 0 means a full memory: the index wraps back to 0 after the last address.
    assign is_last_word = (INST_ADDRS_BITS'(index_reg + 1'b1) == word_count_reg);

    inst_assembler #(
        .UART_BITS(UART_BITS),
        .WORD_BITS(INSTRUCTION_BITS)
    ) u_inst_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_reg == LOAD_COUNT),
        .byte_valid(asm_valid),
        .byte_data (i_rx_data),
        .word      (asm_word),
        .word_ready(asm_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            word_count_reg   <= '0;
            index_reg        <= '0;
            last_reg         <= 1'b0;
            halted_reg       <= 1'b0;
            send_start_reg   <= 1'b0;
            proc_enable_reg  <= 1'b0;
            proc_reset_reg   <= 1'b0;
            inst_write_reg   <= 1'b0;
            inst_address_reg <= '0;
            inst_data_reg    <= '0;
            clk_count_reg    <= '0;
            busy_reg         <= 1'b0;
        end else begin
            send_start_reg <= 1'b0;
            proc_reset_reg <= 1'b0;
            inst_write_reg <= 1'b0;
            // Every enabled pipeline cycle is counted; later clears in this block take priority.
            if (proc_enable_reg && (clk_count_reg != '1))
                clk_count_reg <= clk_count_reg + 1'b1;

            case (state_reg)
                IDLE: begin
                    if (i_rx_done) begin
                        if (i_rx_data == UART_BITS'(CMD_LOAD)) begin
                            state_reg <= LOAD_COUNT;
                            busy_reg  <= 1'b1;
                        end else if ((i_rx_data == UART_BITS'(CMD_RUN)) ||
                                     (i_rx_data == UART_BITS'(CMD_STEP))) begin
                            busy_reg <= 1'b1;
                            if (halted_reg) begin
                                state_reg      <= SEND_START;
                                send_start_reg <= 1'b1;
                            end else begin
                                state_reg       <= (i_rx_data == UART_BITS'(CMD_RUN)) ? RUN : STEP;
                                proc_enable_reg <= 1'b1;
                            end
                        end else if (i_rx_data == UART_BITS'(CMD_RESET)) begin
                            proc_reset_reg <= 1'b1;
                            clk_count_reg  <= '0;
                            halted_reg     <= 1'b0;
                        end
                    end
                end
                LOAD_COUNT: begin
                    if (i_rx_done) begin
                        word_count_reg <= INST_ADDRS_BITS'(i_rx_data);
                        index_reg      <= '0;
                        state_reg      <= LOAD_BYTES;
                    end
                end
                LOAD_BYTES: begin
                    if (asm_ready) begin
                        inst_write_reg   <= 1'b1;
                        inst_address_reg <= index_reg;
                        inst_data_reg    <= asm_word;
                        last_reg         <= is_last_word;
                        state_reg        <= LOAD_WRITE;
                        if (is_last_word) begin
                            proc_reset_reg <= 1'b1;
                            clk_count_reg  <= '0;
                            halted_reg     <= 1'b0;
                        end
                    end
                end
                LOAD_WRITE: begin
                    index_reg <= index_reg + 1'b1;
                    if (last_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= LOAD_BYTES;
                    end
                end
                RUN: begin
                    if (i_halt) begin
                        halted_reg      <= 1'b1;
                        proc_enable_reg <= 1'b0;
                        send_start_reg  <= 1'b1;
                        state_reg       <= SEND_START;
                    end
                end
                STEP: begin
                    halted_reg      <= halted_reg | i_halt;
                    proc_enable_reg <= 1'b0;
                    send_start_reg  <= 1'b1;
                    state_reg       <= SEND_START;
                end
                SEND_START: begin
                    state_reg <= SEND_WAIT;
                end
                SEND_WAIT: begin
                    if (i_send_done) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    busy_reg        <= 1'b0;
                    proc_enable_reg <= 1'b0;
                end
            endcase
        end
    end

    assign o_send_start   = send_start_reg;
    assign o_proc_enable  = proc_enable_reg;
    assign o_proc_reset   = proc_reset_reg;
    assign o_inst_write   = inst_write_reg;
    assign o_inst_address = inst_address_reg;
    assign o_inst_data    = inst_data_reg;
    assign o_clk_count    = clk_count_reg;
    assign o_busy         = busy_reg;

endmodule

// File: doc/debug_controller.md
# debug_controller

Top-level sequencer of the MIPS debug unit. It decodes command bytes arriving from the UART receiver and drives the pipeline's instruction-memory write port, processor enable and processor reset. After every run or step it hands off to `SendDataFSM`, which dumps registers, pipeline latches, data memory and the cycle count.

## Interface
Parameters:
- `UART_BITS`, 8, width of a UART byte.
- `INSTRUCTION_BITS`, 32, instruction width; must be 4·`UART_BITS`.
- `INST_ADDRS_BITS`, 8, instruction-memory word-address width.
- `CLK_COUNT_BITS`, 8, width of the executed-cycle counter.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `i_rx_done` in 1: one-cycle pulse; `i_rx_data` is valid.
- `i_rx_data` in `UART_BITS`: received byte.
- `i_halt` in 1: pipeline has retired HALT; level, sampled only while `o_proc_enable`=1.
- `i_send_done` in 1: `SendDataFSM` `o_done` pulse.
- `o_send_start` out 1: one-cycle start pulse to `SendDataFSM`.
- `o_proc_enable` out 1: pipeline clock enable.
- `o_proc_reset` out 1: one-cycle pipeline reset pulse.
- `o_inst_write` out 1: instruction-memory write strobe.
- `o_inst_address` out `INST_ADDRS_BITS`: write word address.
- `o_inst_data` out `INSTRUCTION_BITS`: write data.
- `o_clk_count` out `CLK_COUNT_BITS`: processor cycles executed since the last program reset.
- `o_busy` out 1: high in every state except IDLE.

## Operation
Command bytes, accepted only in IDLE:
- 0x01 LOAD
- 0x02 RUN
- 0x03 STEP
- 0x04 RESET
- Any other byte is dropped and the FSM stays in IDLE.

States: IDLE, LOAD_COUNT, LOAD_BYTES, LOAD_WRITE, RUN, STEP, SEND_START, SEND_WAIT.

- **LOAD**
  - IDLE→LOAD_COUNT. The next byte is N, the word count; N=0 means 2^`INST_ADDRS_BITS` words.
  - LOAD_BYTES shifts 4 bytes big-endian into a word register; the first byte goes to [31:24].
  - On the 4th byte, go to LOAD_WRITE. There `o_inst_write`=1 for exactly one cycle, with `o_inst_address` = word index (starting at 0) and `o_inst_data` = the assembled word.
  - Then increment the index. If index = N (mod 2^`INST_ADDRS_BITS`), go to IDLE; otherwise return to LOAD_BYTES.
  - On completion: pulse `o_proc_reset`, clear `o_clk_count` and clear the halted flag, all in the same cycle as the last write.
- **RUN**
  - If the halted flag is set: go directly to SEND_START.
  - Otherwise `o_proc_enable`=1 in every RUN cycle, and each enabled cycle increments `o_clk_count`, saturating at all-ones.
  - When `i_halt`=1 in an enabled cycle: that cycle is counted, the halted flag is set, and the FSM goes to SEND_START.
- **STEP**
  - If not halted: exactly one enabled, counted cycle. `i_halt` in that cycle sets the halted flag.
  - Then go to SEND_START.
- **RESET**
  - Pulse `o_proc_reset`, clear the counter and the halted flag, stay in IDLE. No dump is sent.
- **SEND_START**
  - `o_send_start`=1 for one cycle, then go to SEND_WAIT.
  - SEND_WAIT goes to IDLE on `i_send_done`.
- `i_rx_done` is ignored in RUN, STEP, SEND_START and SEND_WAIT; those bytes are lost. LOAD has no timeout.

## Timing
- **Reset values:**
  - state IDLE;
  - all strobes 0 (`o_proc_enable`, `o_proc_reset`, `o_send_start`, `o_inst_write`);
  - `o_inst_address`=0, `o_inst_data`=0, `o_clk_count`=0;
  - halted flag 0, `o_busy`=0.
- All outputs are registered. A command byte on cycle t produces the state change at t+1.
- For RUN and STEP, `o_proc_enable` first rises at t+1.
- `o_inst_write` asserts at t+1 after the 4th byte's `i_rx_done`.
- `o_send_start` asserts the cycle after the last enabled cycle. `o_proc_enable` is never high together with `o_send_start`.
- If `i_send_done` is high in the SEND_START cycle, it is ignored; only SEND_WAIT samples it.
- `rst` in any state returns to IDLE on the next edge. Partial LOAD data is discarded and no write is issued.

## Structure
- The shared `constants.vh` gains:
  - command opcodes: `CMD_LOAD`, `CMD_RUN`, `CMD_STEP`, `CMD_RESET`;
  - `INST_ADDRS_BITS`;
  - `CLK_COUNT_BITS`.
- State encodings are local parameters.
- One sub-module, `inst_assembler`: byte shift register plus byte counter, producing the word and a `word_ready` pulse.

## Test plan
- **LOAD:** send 0x01, 0x02, then 8 bytes 0x20,0x01,0x00,0x05,0xFC,0x00,0x00,0x00.
  - Expect a write to address 0 with data 0x20010005, then a write to address 1 with data 0xFC000000.
  - Expect one `o_proc_reset` pulse and `o_clk_count`=0.
- **RUN:** send 0x02; `i_halt` rises on the 5th enabled cycle.
  - Expect `o_proc_enable` high for exactly 5 cycles and `o_clk_count`=5.
  - Expect one `o_send_start` the next cycle, and IDLE after `i_send_done`.
- **STEP:** send 0x03 three times, answering each `o_send_start` with `i_send_done`.
  - Expect 3 single-cycle enables and `o_clk_count`=3.
- **STEP when halted:** after a halt, send 0x03.
  - Expect no enable, count unchanged, `o_send_start` at t+1.
- **Saturation:** RUN 300 cycles before `i_halt`.
  - Expect `o_clk_count`=255.
- **Reset and dropped bytes:** assert `rst` after 2 of 4 LOAD data bytes.
  - Expect IDLE, no `o_inst_write`, and 0x05 afterwards dropped.
  - Bytes received during SEND_WAIT produce no action.
